// File: rtl/leve2_pkg.sv
// leve2_pkg: shared decode constants, instruction layout and forwarding-source
// enum for the LEVE2 decode/operand-read stage.
package leve2_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned INSTR_W   = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_32  = 7'b0111011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_src_e;

  // Common field layout shared by all RV32/RV64 base formats.
  typedef struct packed {
    logic [6:0]           funct7;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rs1;
    logic [2:0]           funct3;
    logic [REG_IDX_W-1:0] rd;
    logic [6:0]           opcode;
  } instr_t;

  // CSR immediate forms (funct3[2]=1) take a zimm in the rs1 field.
  function automatic logic uses_rs1(input instr_t i);
    return !((i.opcode == OPC_LUI) || (i.opcode == OPC_AUIPC) ||
             (i.opcode == OPC_JAL) ||
             ((i.opcode == OPC_SYSTEM) && i.funct3[2]));
  endfunction

  function automatic logic uses_rs2(input instr_t i);
    return (i.opcode == OPC_OP) || (i.opcode == OPC_OP_32) ||
           (i.opcode == OPC_STORE) || (i.opcode == OPC_BRANCH);
  endfunction

  function automatic logic writes_rd(input instr_t i);
    return (i.opcode != OPC_STORE) && (i.opcode != OPC_BRANCH) &&
           (i.rd != '0);
  endfunction

endpackage

// File: rtl/leve2_regfile.sv
// leve2_regfile: NREG x XLEN integer register file, two combinational reads,
// one synchronous write. x0 reads as zero; indices >= NREG read as zero and
// writes to them are dropped. Contents are not reset.
// Ports:
//   clk                 clock
//   raddr1/raddr2       read indices (5 bit)
//   rdata1_c/rdata2_c   combinational read data
//   we/waddr/wdata      write port, applied on rising edge
module leve2_regfile
  import leve2_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input  logic                 clk,
  input  logic [REG_IDX_W-1:0] raddr1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [XLEN-1:0]      rdata1_c,
  output logic [XLEN-1:0]      rdata2_c,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]      wdata
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];

  function automatic logic in_range(input logic [REG_IDX_W-1:0] idx);
    return (idx != '0) && (32'(idx) < NREG);
  endfunction

  assign rdata1_c = in_range(raddr1) ? regs[raddr1[AW-1:0]] : '0;
  assign rdata2_c = in_range(raddr2) ? regs[raddr2[AW-1:0]] : '0;

  // Storage only; no reset so it maps onto plain flops/SRAM.
  always_ff @(posedge clk) begin
    if (we && in_range(waddr)) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/leve2_id_stage.sv
// leve2_id_stage: decode/operand-read stage of the LEVE2 in-order pipeline.
// Reads operands from the register file with EX/MEM forwarding, interlocks on
// load-use, handshakes valid/ready on both sides and delays WB valid/PC by one
// cycle for retire tracking.
// Build option: LEVE2_WB_BYPASS_EN forwards a same-cycle WB write to the
// operand read; without it a WB-to-source match stalls one cycle instead.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   ivalid/iready, ipc/iinstr      fetch-side handshake and payload
//   ovalid/oready, opc/oinstr      execute-side handshake and payload
//   rs1/rs2                        registered operands
//   ex_rd                          EX result of the instruction in oinstr
//   mem_valid/mem_we/mem_rdidx/mem_rd   MEM stage destination info
//   wb_ivalid/wb_iwe/wb_ipc/wb_iinstr/wb_ird  writeback inputs
//   wb_ovalid/wb_opc               writeback valid/PC delayed one cycle
module leve2_id_stage
  import leve2_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ivalid,
  output logic                 iready,
  input  logic [XLEN-1:0]      ipc,
  input  logic [INSTR_W-1:0]   iinstr,
  output logic                 ovalid,
  input  logic                 oready,
  output logic [XLEN-1:0]      opc,
  output logic [INSTR_W-1:0]   oinstr,
  output logic [XLEN-1:0]      rs1,
  output logic [XLEN-1:0]      rs2,
  input  logic [XLEN-1:0]      ex_rd,
  input  logic                 mem_valid,
  input  logic                 mem_we,
  input  logic [REG_IDX_W-1:0] mem_rdidx,
  input  logic [XLEN-1:0]      mem_rd,
  input  logic                 wb_ivalid,
  input  logic                 wb_iwe,
  input  logic [XLEN-1:0]      wb_ipc,
  input  logic [INSTR_W-1:0]   wb_iinstr,
  input  logic [XLEN-1:0]      wb_ird,
  output logic                 wb_ovalid,
  output logic [XLEN-1:0]      wb_opc
);

  instr_t               in_dec;
  instr_t               ex_dec;
  logic                 in_uses_rs1;
  logic                 in_uses_rs2;
  logic                 ex_wr;
  logic                 ex_load;
  logic [REG_IDX_W-1:0] wb_rdidx;
  logic                 wb_fwd;
  logic                 load_use;
  logic                 wb_conflict;
  logic                 adv;
  logic                 accept;
  logic [XLEN-1:0]      rf_rdata1;
  logic [XLEN-1:0]      rf_rdata2;
  fwd_src_e             src1;
  fwd_src_e             src2;
  logic [XLEN-1:0]      op1;
  logic [XLEN-1:0]      op2;
  logic                 unused_bits;

  assign in_dec   = instr_t'(iinstr);
  assign ex_dec   = instr_t'(oinstr);
  assign wb_rdidx = wb_iinstr[11:7];

  assign unused_bits = ^{in_dec.funct7, in_dec.funct3[1:0], ex_dec.funct7,
                         ex_dec.rs2, ex_dec.rs1, ex_dec.funct3,
                         wb_iinstr[31:12], wb_iinstr[6:0]};

  assign in_uses_rs1 = uses_rs1(in_dec);
  assign in_uses_rs2 = uses_rs2(in_dec);

  // EX-stage instruction attributes; a bubble (ovalid=0) never writes.
  assign ex_wr   = ovalid && writes_rd(ex_dec);
  assign ex_load = (ex_dec.opcode == OPC_LOAD);

`ifdef LEVE2_WB_BYPASS_EN
  assign wb_fwd      = wb_iwe;
  assign wb_conflict = 1'b0;
`else
  assign wb_fwd      = 1'b0;
  // The RF write lands at this edge, so a matching read would see stale data.
  assign wb_conflict = ivalid && wb_iwe && (wb_rdidx != '0) &&
                       ((in_uses_rs1 && (in_dec.rs1 == wb_rdidx)) ||
                        (in_uses_rs2 && (in_dec.rs2 == wb_rdidx)));
`endif

  // Load data is not available until MEM, so a load in EX is never forwarded.
  assign load_use = ivalid && ex_wr && ex_load &&
                    ((in_uses_rs1 && (in_dec.rs1 == ex_dec.rd)) ||
                     (in_uses_rs2 && (in_dec.rs2 == ex_dec.rd)));

  assign adv    = !ovalid || oready;
  assign iready = adv && !load_use && !wb_conflict;
  assign accept = ivalid && iready;

  // Forwarding priority: zero, EX, MEM, WB (bypass build), register file.
  function automatic fwd_src_e pick_src(
    input logic [REG_IDX_W-1:0] idx,
    input logic                 ex_hit_en,
    input logic [REG_IDX_W-1:0] ex_idx,
    input logic                 mem_hit_en,
    input logic [REG_IDX_W-1:0] mem_idx,
    input logic                 wb_hit_en,
    input logic [REG_IDX_W-1:0] wb_idx
  );
    if ((idx == '0) || (32'(idx) >= NREG)) return FWD_ZERO;
    if (ex_hit_en && (idx == ex_idx))      return FWD_EX;
    if (mem_hit_en && (idx == mem_idx))    return FWD_MEM;
    if (wb_hit_en && (idx == wb_idx))      return FWD_WB;
    return FWD_RF;
  endfunction

  assign src1 = pick_src(in_dec.rs1, ex_wr && !ex_load, ex_dec.rd,
                         mem_valid && mem_we, mem_rdidx, wb_fwd, wb_rdidx);
  assign src2 = pick_src(in_dec.rs2, ex_wr && !ex_load, ex_dec.rd,
                         mem_valid && mem_we, mem_rdidx, wb_fwd, wb_rdidx);

  // Operand muxes.
  always_comb begin
    op1 = rf_rdata1;
    op2 = rf_rdata2;
    case (src1)
      FWD_ZERO: op1 = '0;
      FWD_EX:   op1 = ex_rd;
      FWD_MEM:  op1 = mem_rd;
      FWD_WB:   op1 = wb_ird;
      default:  op1 = rf_rdata1;
    endcase
    case (src2)
      FWD_ZERO: op2 = '0;
      FWD_EX:   op2 = ex_rd;
      FWD_MEM:  op2 = mem_rd;
      FWD_WB:   op2 = wb_ird;
      default:  op2 = rf_rdata2;
    endcase
  end

  leve2_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .raddr1   (in_dec.rs1),
    .raddr2   (in_dec.rs2),
    .rdata1_c (rf_rdata1),
    .rdata2_c (rf_rdata2),
    .we       (wb_iwe),
    .waddr    (wb_rdidx),
    .wdata    (wb_ird)
  );

  // ID/EX pipeline register; holds while EX back-pressures, bubbles on no accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovalid <= 1'b0;
      opc    <= '0;
      oinstr <= NOP;
      rs1    <= '0;
      rs2    <= '0;
    end else if (adv) begin
      ovalid <= accept;
      if (accept) begin
        opc    <= ipc;
        oinstr <= iinstr;
        rs1    <= op1;
        rs2    <= op2;
      end else begin
        oinstr <= NOP;
      end
    end
  end

  // Retire tracking: WB valid/PC delayed one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ovalid <= 1'b0;
      wb_opc    <= '0;
    end else begin
      wb_ovalid <= wb_ivalid;
      wb_opc    <= wb_ipc;
    end
  end

endmodule

// File: tb/tb_leve2_id_stage.sv
// tb_leve2_id_stage: directed self-checking bench for leve2_id_stage.
module tb_leve2_id_stage;
  import leve2_pkg::*;

  localparam int unsigned XLEN = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ivalid;
  logic                 iready;
  logic [XLEN-1:0]      ipc;
  logic [31:0]          iinstr;
  logic                 ovalid;
  logic                 oready;
  logic [XLEN-1:0]      opc;
  logic [31:0]          oinstr;
  logic [XLEN-1:0]      rs1;
  logic [XLEN-1:0]      rs2;
  logic [XLEN-1:0]      ex_rd;
  logic                 mem_valid;
  logic                 mem_we;
  logic [4:0]           mem_rdidx;
  logic [XLEN-1:0]      mem_rd;
  logic                 wb_ivalid;
  logic                 wb_iwe;
  logic [XLEN-1:0]      wb_ipc;
  logic [31:0]          wb_iinstr;
  logic [XLEN-1:0]      wb_ird;
  logic                 wb_ovalid;
  logic [XLEN-1:0]      wb_opc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  leve2_id_stage #(.XLEN(64), .NREG(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ivalid    (ivalid),
    .iready    (iready),
    .ipc       (ipc),
    .iinstr    (iinstr),
    .ovalid    (ovalid),
    .oready    (oready),
    .opc       (opc),
    .oinstr    (oinstr),
    .rs1       (rs1),
    .rs2       (rs2),
    .ex_rd     (ex_rd),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_rdidx (mem_rdidx),
    .mem_rd    (mem_rd),
    .wb_ivalid (wb_ivalid),
    .wb_iwe    (wb_iwe),
    .wb_ipc    (wb_ipc),
    .wb_iinstr (wb_iinstr),
    .wb_ird    (wb_ird),
    .wb_ovalid (wb_ovalid),
    .wb_opc    (wb_opc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [4:0] ra, input logic [4:0] rb);
    return {7'd0, rb, ra, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] i_type(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] ra,
                                         input logic [11:0] imm);
    return {imm, ra, f3, rd, op};
  endfunction

  initial begin
    logic [31:0] add6, addi7, add8, ld8, add9, add10, or4, wb_x5, wb_x3;
    add6  = r_type(3'b000, 5'd6, 5'd5, 5'd0);
    addi7 = i_type(7'b0010011, 3'b000, 5'd7, 5'd0, 12'h005);
    add8  = r_type(3'b000, 5'd8, 5'd7, 5'd7);
    ld8   = i_type(OPC_LOAD, 3'b011, 5'd8, 5'd5, 12'h000);
    add9  = r_type(3'b000, 5'd9, 5'd8, 5'd0);
    add10 = r_type(3'b000, 5'd10, 5'd5, 5'd0);
    or4   = r_type(3'b110, 5'd4, 5'd3, 5'd0);
    wb_x5 = r_type(3'b000, 5'd5, 5'd0, 5'd0);
    wb_x3 = r_type(3'b000, 5'd3, 5'd0, 5'd0);

    rst_n = 1'b0; ivalid = 1'b0; ipc = '0; iinstr = NOP; oready = 1'b1;
    ex_rd = '0; mem_valid = 1'b0; mem_we = 1'b0; mem_rdidx = '0; mem_rd = '0;
    wb_ivalid = 1'b0; wb_iwe = 1'b0; wb_ipc = '0; wb_iinstr = NOP; wb_ird = '0;

    // Reset state
    #12;
    check("rst_ovalid", 64'(ovalid), 64'd0);
    check("rst_oinstr", 64'(oinstr), 64'h13);
    check("rst_iready", 64'(iready), 64'd1);
    check("rst_wb_ovalid", 64'(wb_ovalid), 64'd0);
    check("rst_opc", opc, 64'd0);
    check("rst_rs1", rs1, 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_ovalid", 64'(ovalid), 64'd0);
    check("idle_oinstr", 64'(oinstr), 64'h13);

    // WB write x5 = 0x1234, also exercises WB valid/PC delay
    wb_ivalid = 1'b1; wb_iwe = 1'b1; wb_ipc = 64'h100; wb_iinstr = wb_x5; wb_ird = 64'h1234;
    tick();
    check("wb_ovalid_set", 64'(wb_ovalid), 64'd1);
    check("wb_opc", wb_opc, 64'h100);
    wb_ivalid = 1'b0; wb_iwe = 1'b0;
    tick();
    check("wb_ovalid_clr", 64'(wb_ovalid), 64'd0);

    // ADD x6,x5,x0 reads the register file
    ivalid = 1'b1; ipc = 64'h200; iinstr = add6;
    #1 check("add6_iready", 64'(iready), 64'd1);
    tick();
    check("add6_ovalid", 64'(ovalid), 64'd1);
    check("add6_opc", opc, 64'h200);
    check("add6_oinstr", 64'(oinstr), 64'(add6));
    check("add6_rs1", rs1, 64'h1234);
    check("add6_rs2", rs2, 64'd0);

    // ADDI x7 then ADD x8,x7,x7 forwarded from EX
    ipc = 64'h204; iinstr = addi7; ex_rd = 64'h1234;
    tick();
    check("addi7_oinstr", 64'(oinstr), 64'(addi7));
    check("addi7_rs1", rs1, 64'd0);
    ipc = 64'h208; iinstr = add8; ex_rd = 64'hAA;
    #1 check("add8_iready", 64'(iready), 64'd1);
    tick();
    check("add8_rs1", rs1, 64'hAA);
    check("add8_rs2", rs2, 64'hAA);

    // LD x8 then ADD x9,x8,x0: one bubble, then MEM forward
    ipc = 64'h20C; iinstr = ld8; ex_rd = 64'h154;
    tick();
    check("ld8_oinstr", 64'(oinstr), 64'(ld8));
    check("ld8_rs1", rs1, 64'h1234);
    ipc = 64'h210; iinstr = add9; ex_rd = 64'hDEAD;
    #1 check("lu_iready_stall", 64'(iready), 64'd0);
    tick();
    check("lu_bubble_ovalid", 64'(ovalid), 64'd0);
    check("lu_bubble_oinstr", 64'(oinstr), 64'h13);
    mem_valid = 1'b1; mem_we = 1'b1; mem_rdidx = 5'd8; mem_rd = 64'hBEEF;
    #1 check("lu_iready_go", 64'(iready), 64'd1);
    tick();
    check("add9_ovalid", 64'(ovalid), 64'd1);
    check("add9_oinstr", 64'(oinstr), 64'(add9));
    check("add9_opc", opc, 64'h210);
    check("add9_rs1", rs1, 64'hBEEF);
    mem_valid = 1'b0; mem_we = 1'b0;

    // EX backpressure for 3 cycles
    oready = 1'b0; ipc = 64'h300; iinstr = add10; ex_rd = 64'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("bp%0d_iready", i), 64'(iready), 64'd0);
      tick();
      check($sformatf("bp%0d_ovalid", i), 64'(ovalid), 64'd1);
      check($sformatf("bp%0d_oinstr", i), 64'(oinstr), 64'(add9));
      check($sformatf("bp%0d_opc", i), opc, 64'h210);
      check($sformatf("bp%0d_rs1", i), rs1, 64'hBEEF);
    end
    oready = 1'b1;
    #1 check("bp_release_iready", 64'(iready), 64'd1);
    tick();
    check("add10_oinstr", 64'(oinstr), 64'(add10));
    check("add10_opc", opc, 64'h300);
    check("add10_rs1", rs1, 64'h1234);

    // Same-cycle WB write of x3 while OR x4,x3,x0 is presented
    ex_rd = 64'h1234;
    wb_ivalid = 1'b1; wb_iwe = 1'b1; wb_ipc = 64'h180; wb_iinstr = wb_x3; wb_ird = 64'h55;
    ipc = 64'h304; iinstr = or4;
`ifdef LEVE2_WB_BYPASS_EN
    #1 check("wbc_iready", 64'(iready), 64'd1);
    tick();
    wb_ivalid = 1'b0; wb_iwe = 1'b0;
`else
    #1 check("wbc_iready_stall", 64'(iready), 64'd0);
    tick();
    check("wbc_bubble_ovalid", 64'(ovalid), 64'd0);
    check("wbc_bubble_oinstr", 64'(oinstr), 64'h13);
    wb_ivalid = 1'b0; wb_iwe = 1'b0;
    #1 check("wbc_iready_go", 64'(iready), 64'd1);
    tick();
`endif
    check("or4_oinstr", 64'(oinstr), 64'(or4));
    check("or4_rs1", rs1, 64'h55);

    // Reset asserted while a load-use stall is pending
    ipc = 64'h400; iinstr = ld8;
    tick();
    check("ld8b_oinstr", 64'(oinstr), 64'(ld8));
    iinstr = add9; ipc = 64'h404;
    #1 check("rst_stall_iready", 64'(iready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ovalid", 64'(ovalid), 64'd0);
    check("rst_mid_oinstr", 64'(oinstr), 64'h13);
    check("rst_mid_iready", 64'(iready), 64'd1);
    ivalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ovalid", 64'(ovalid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leve2_id_stage.md
# leve2_id_stage

Parametrised decode/operand-read stage for the LEVE2 in-order pipeline, between fetch and execute. It holds the integer register file and forwards results from the EX and MEM stages. It also forwards from WB when that feature is compiled in. A load-use interlock and valid/ready handshakes on both sides let EX apply backpressure. It also registers the WB valid/PC pair for retire tracking.

## Interface
- XLEN, 64: datapath and PC width.
- NREG, 32: architectural registers, 32 or 16 (RV-E); register index width is fixed at 5 bits. With NREG=16, indices 16-31 read as 0 and writes to them are dropped.
- CLK  in  1  clock; all state updates on rising edge.
- RSTn  in  1  reset; one clock; reset is asynchronous and active-low.
- IVALID / IREADY  in / out  1 / 1  fetch-side handshake.
- IPC / IINSTR  in  XLEN / 32  incoming PC and instruction.
- OVALID / OREADY  out / in  1 / 1  execute-side handshake.
- OPC / OINSTR  out  XLEN / 32  registered PC and instruction.
- RS1 / RS2  out  XLEN each  registered operands.
- EX_RD  in  XLEN  EX result of the instruction currently in OINSTR (combinational from EX).
- MEM_VALID / MEM_WE  in  1 / 1  MEM stage occupancy and register-write flag.
- MEM_RDIDX / MEM_RD  in  5 / XLEN  MEM destination index and result (load data included).
- WB_IVALID / WB_IWE  in  1 / 1  writeback valid and register-write enable.
- WB_IPC / WB_IINSTR / WB_IRD  in  XLEN / 32 / XLEN  writeback PC, instruction (rd = [11:7]) and data.
- WB_OVALID / WB_OPC  out  1 / XLEN  writeback valid/PC delayed one cycle.

## Operation
- Decode: rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0].
- uses_rs1 holds for every opcode except LUI, AUIPC and JAL, and except SYSTEM with funct3[2]=1.
- uses_rs2 holds for OP, OP-32, STORE and BRANCH.
- The EX-stage instruction writes rd when OVALID=1, its opcode is not STORE or BRANCH, and rd≠0. It is a load when its opcode is 0000011.
- Operand source, per operand, first match wins:
  - index 0 → 0;
  - EX writes and rd matches, not a load → EX_RD;
  - MEM_VALID, MEM_WE and MEM_RDIDX match → MEM_RD;
  - WB_IWE and WB rd matches → WB_IRD (macro only);
  - otherwise the register file.
- load_use = IVALID && the EX instruction is a load writing rd && a used source equals that rd.
- wb_conflict = IVALID && WB_IWE && WB rd≠0 && a used source equals WB rd. It is non-zero only without the macro.
- adv = !OVALID || OREADY.
- IREADY = adv && !load_use && !wb_conflict. IREADY depends combinationally on IINSTR and OREADY.
- On adv:
  - OVALID <= IVALID && IREADY;
  - OPC, OINSTR, RS1 and RS2 load on acceptance;
  - if not accepted, the bubble leaves OINSTR = 0x00000013.
- When adv=0, all O* outputs hold.
- Register file write: WB_IWE && rd≠0 writes WB_IRD at the clock edge, independent of the handshakes. Writes to x0 are ignored.
- WB_OVALID <= WB_IVALID and WB_OPC <= WB_IPC every cycle.

## Timing
- Reset values:
  - OVALID=0, OPC=0, OINSTR=0x00000013, RS1=RS2=0;
  - WB_OVALID=0, WB_OPC=0;
  - IREADY=1 after reset, since OVALID=0 and IVALID=0;
  - register file contents are not reset (undefined).
- Latency: accepted on edge N → on OVALID/OPC/OINSTR/RS1/RS2 after edge N.
- Load-use: the consumer stalls until the load leaves EX. The bubble is issued on the same adv cycle. The next cycle the load is in MEM and the consumer is accepted via MEM_RD. The penalty is exactly 1 cycle.
- Reset asserted mid-stall clears OVALID immediately. An in-flight instruction is dropped, not replayed.

## Configuration
- LEVE2_WB_BYPASS_EN defined: a same-cycle WB write is forwarded to the read and wb_conflict is 0. There is no stall.
- Not defined: wb_conflict stalls one cycle, and the operand is then read from the updated register file.

## Structure
- Package leve2_pkg holds:
  - opcode constants (LOAD, STORE, BRANCH, OP, OP_32, LUI, AUIPC, JAL, SYSTEM);
  - the NOP constant 32'h00000013;
  - the fwd_src_e enum (ZERO, EX, MEM, WB, RF).
- Sub-module leve2_regfile: parametrised NREG×XLEN, 2 combinational reads, 1 synchronous write, x0 hardwired to 0.

## Test plan
- Reset with OREADY=1 → OVALID=0, OINSTR=0x00000013, IREADY=1, WB_OVALID=0.
- WB write x5=0x1234; two cycles later issue ADD x6,x5,x0 → RS1=0x1234, RS2=0 one cycle after acceptance.
- ADDI x7 is in OINSTR with EX_RD=0xAA; next instruction ADD x8,x7,x7 → RS1=RS2=0xAA.
- LD x8 then ADD x9,x8,x0:
  - first: IREADY=0 for 1 cycle and a bubble with OVALID=0;
  - then the ADD is accepted with MEM_RD=0xBEEF → RS1=0xBEEF.
- OREADY=0 for 3 cycles with OVALID=1 → O* outputs stable and IREADY=0; the instruction is accepted in the cycle after OREADY returns to 1.
- WB writes x3=0x55 in the same cycle that OR x4,x3,x0 is presented:
  - macro defined → no stall, RS1=0x55;
  - macro undefined → 1-cycle IREADY=0, then RS1=0x55.
